// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet store-and-forward port router.
package eth_pkg;

    localparam int WORD_W  = 34;
    localparam int SOP_BIT = 32;
    localparam int EOP_BIT = 33;

    typedef logic [WORD_W-1:0] eth_word_t;

    localparam logic [31:0] DEF_PORTA_ADDR = 32'h0000_ABCD;
    localparam logic [31:0] DEF_PORTB_ADDR = 32'h0000_BEEF;

    typedef enum logic [1:0] {
        IN_IDLE,
        IN_PKT,
        IN_DROP
    } in_state_e;

    typedef enum logic [2:0] {
        OUT_IDLE,
        OUT_ROUTE,
        OUT_FWD_A,
        OUT_FWD_B,
        OUT_DISCARD
    } out_state_e;

endpackage

// File: rtl/eth_pkt_fifo.sv
// Packet FIFO with a speculative write pointer: words become visible to the
// reader only once committed, and a partial packet can be rewound away.
module eth_pkt_fifo
    import eth_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  eth_word_t                wr_data,
    input  logic                     rewind,
    input  logic                     commit,
    input  logic                     pop,
    output eth_word_t                head_data,
    output logic                     committed,
    output logic [$clog2(DEPTH):0]   free_cnt
);

    localparam int PW = $clog2(DEPTH) + 1;
    localparam logic [PW-1:0] DEPTH_W = PW'(DEPTH);

    eth_word_t       mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   commit_ptr_q, commit_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_base;

    // A rewind and a write in the same cycle restarts the packet at commit_ptr.
    always_comb begin
        wr_base      = rewind ? commit_ptr_q : wr_ptr_q;
        wr_ptr_d     = wr_base + {{(PW-1){1'b0}}, wr_en};
        commit_ptr_d = commit ? wr_ptr_d : commit_ptr_q;
        rd_ptr_d     = rd_ptr_q + {{(PW-1){1'b0}}, pop};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_base[PW-2:0]] <= wr_data;
        end
    end

    // Room is measured from commit_ptr: new packets only start once any
    // partial packet has been committed or rewound, so wr_ptr equals it then.
    always_comb begin
        head_data = mem_q[rd_ptr_q[PW-2:0]];
        committed = (rd_ptr_q != commit_ptr_q);
        free_cnt  = DEPTH_W - (commit_ptr_q - rd_ptr_q);
    end

endmodule

// File: rtl/eth_port_router.sv
// Store-and-forward router: buffers whole packets from the receive FSM and
// forwards each committed packet to port A or B by its destination word.
module eth_port_router
    import eth_pkg::*;
#(
    parameter int          DEPTH         = 64,
    parameter int          MAX_PKT_WORDS = 16,
    parameter logic [31:0] PORTA_ADDR    = DEF_PORTA_ADDR,
    parameter logic [31:0] PORTB_ADDR    = DEF_PORTB_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inWrEn,
    input  logic [33:0] inData,
    output logic        portAValid,
    output logic [33:0] portAData,
    input  logic        portAReady,
    output logic        portBValid,
    output logic [33:0] portBData,
    input  logic        portBReady,
    output logic [15:0] dropCnt,
    output logic [15:0] unroutedCnt
);

    localparam int PW = $clog2(DEPTH) + 1;
    localparam int CW = $clog2(MAX_PKT_WORDS + 1);
    localparam logic [PW-1:0] MAX_FREE = PW'(MAX_PKT_WORDS);
    localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_PKT_WORDS);

    function automatic logic [15:0] sat_add(input logic [15:0] cnt, input logic [1:0] inc);
        logic [16:0] sum;
        sum = {1'b0, cnt} + {15'd0, inc};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    in_state_e     in_state_q, in_state_d;
    out_state_e    out_state_q, out_state_d;
    logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;
    logic [15:0]   unrouted_cnt_q, unrouted_cnt_d;

    logic          fifo_wr_en, fifo_rewind, fifo_commit, fifo_pop;
    logic          fifo_committed;
    eth_word_t     head;
    logic [PW-1:0] free_cnt;
    logic [1:0]    drop_inc;
    logic          unrouted_inc;
    logic          a_valid, b_valid;
    logic          in_sop, in_eop, head_eop;

    eth_pkt_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (fifo_wr_en),
        .wr_data   (inData),
        .rewind    (fifo_rewind),
        .commit    (fifo_commit),
        .pop       (fifo_pop),
        .head_data (head),
        .committed (fifo_committed),
        .free_cnt  (free_cnt)
    );

    assign in_sop   = inData[SOP_BIT];
    assign in_eop   = inData[EOP_BIT];
    assign head_eop = head[EOP_BIT];

    // Ingress: a SOP is handled identically in every state; an SOP that
    // aborts a packet in progress and is itself refused counts two drops.
    always_comb begin
        in_state_d  = in_state_q;
        pkt_cnt_d   = pkt_cnt_q;
        fifo_wr_en  = 1'b0;
        fifo_rewind = 1'b0;
        fifo_commit = 1'b0;
        drop_inc    = 2'd0;
        if (inWrEn) begin
            if (in_sop) begin
                if (in_state_q == IN_PKT) begin
                    fifo_rewind = 1'b1;
                    drop_inc    = 2'd1;
                end
                if (free_cnt >= MAX_FREE) begin
                    fifo_wr_en = 1'b1;
                    if (in_eop) begin
                        fifo_commit = 1'b1;
                        in_state_d  = IN_IDLE;
                    end else begin
                        in_state_d = IN_PKT;
                        pkt_cnt_d  = CW'(1);
                    end
                end else begin
                    drop_inc   = drop_inc + 2'd1;
                    in_state_d = in_eop ? IN_IDLE : IN_DROP;
                end
            end else begin
                case (in_state_q)
                    IN_PKT: begin
                        if (pkt_cnt_q >= MAX_CNT) begin
                            fifo_rewind = 1'b1;
                            drop_inc    = 2'd1;
                            in_state_d  = in_eop ? IN_IDLE : IN_DROP;
                        end else begin
                            fifo_wr_en = 1'b1;
                            pkt_cnt_d  = pkt_cnt_q + CW'(1);
                            if (in_eop) begin
                                fifo_commit = 1'b1;
                                in_state_d  = IN_IDLE;
                            end
                        end
                    end
                    IN_DROP: begin
                        if (in_eop) in_state_d = IN_IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        out_state_d  = out_state_q;
        fifo_pop     = 1'b0;
        unrouted_inc = 1'b0;
        a_valid      = 1'b0;
        b_valid      = 1'b0;
        case (out_state_q)
            OUT_IDLE: begin
                if (fifo_committed) out_state_d = OUT_ROUTE;
            end
            OUT_ROUTE: begin
                if (head[31:0] == PORTA_ADDR) begin
                    out_state_d = OUT_FWD_A;
                end else if (head[31:0] == PORTB_ADDR) begin
                    out_state_d = OUT_FWD_B;
                end else begin
                    out_state_d  = OUT_DISCARD;
                    unrouted_inc = 1'b1;
                end
            end
            OUT_FWD_A: begin
                a_valid = 1'b1;
                if (portAReady) begin
                    fifo_pop = 1'b1;
                    if (head_eop) out_state_d = OUT_IDLE;
                end
            end
            OUT_FWD_B: begin
                b_valid = 1'b1;
                if (portBReady) begin
                    fifo_pop = 1'b1;
                    if (head_eop) out_state_d = OUT_IDLE;
                end
            end
            OUT_DISCARD: begin
                fifo_pop = 1'b1;
                if (head_eop) out_state_d = OUT_IDLE;
            end
            default: out_state_d = OUT_IDLE;
        endcase
    end

    always_comb begin
        drop_cnt_d     = sat_add(drop_cnt_q, drop_inc);
        unrouted_cnt_d = sat_add(unrouted_cnt_q, {1'b0, unrouted_inc});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_state_q     <= IN_IDLE;
            out_state_q    <= OUT_IDLE;
            pkt_cnt_q      <= '0;
            drop_cnt_q     <= '0;
            unrouted_cnt_q <= '0;
        end else begin
            in_state_q     <= in_state_d;
            out_state_q    <= out_state_d;
            pkt_cnt_q      <= pkt_cnt_d;
            drop_cnt_q     <= drop_cnt_d;
            unrouted_cnt_q <= unrouted_cnt_d;
        end
    end

    // Data outputs are gated so an idle port always presents zero.
    assign portAValid  = a_valid;
    assign portBValid  = b_valid;
    assign portAData   = a_valid ? head : '0;
    assign portBData   = b_valid ? head : '0;
    assign dropCnt     = drop_cnt_q;
    assign unroutedCnt = unrouted_cnt_q;

endmodule
